// File: rtl/tt_input_conditioner.sv
// Input conditioner for pad bits: 2-flop synchronizer, per-bit debounce, registered rise/fall pulses.
// Optional auto-repeat of rise pulses while a bit stays high is enabled by defining REPEAT_FEATURE_EN.
module tt_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("tt_input_conditioner: DEBOUNCE_CYCLES must be in 1..65535");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("tt_input_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] rpt_fire;

  // A bit toggles on the edge that completes DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: default every always_comb output before the loop so no path can infer a latch.
    toggle = '0;
    for (int b = 0; b < WIDTH; b++) begin
      toggle[b] = ena && (sync2[b] != level_o[b]) && (cnt[b] == CNT_LAST);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level_o <= '0;
      rise_o  <= '0;
      fall_o  <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is reset like any register.
      for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
    end else begin
      sync1   <= raw_i;
      sync2   <= sync1;
      level_o <= level_o ^ toggle;
      rise_o  <= (toggle & sync2) | rpt_fire;
      fall_o  <= toggle & ~sync2;
      for (int b = 0; b < WIDTH; b++) begin
        if (!ena || (sync2[b] == level_o[b]) || toggle[b]) cnt[b] <= '0;
        else                                               cnt[b] <= cnt[b] + 1'b1;
      end
    end
  end

`ifdef REPEAT_FEATURE_EN
  localparam int DW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int RW = (DW > PW) ? DW : PW;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]    rpt [WIDTH];
  logic [WIDTH-1:0] rpt_armed;  // first repeat already issued; later gaps use REPEAT_PERIOD

  // A falling toggle suppresses the repeat that would land on the same edge.
  always_comb begin
    rpt_fire = '0;
    for (int b = 0; b < WIDTH; b++) begin
      rpt_fire[b] = ena && level_o[b] && !toggle[b] &&
                    (rpt[b] == (rpt_armed[b] ? PER_LAST : DLY_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_armed <= '0;
      for (int b = 0; b < WIDTH; b++) rpt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (!ena || !level_o[b] || toggle[b]) begin
          rpt[b]       <= '0;
          rpt_armed[b] <= 1'b0;
        end else if (rpt_fire[b]) begin
          rpt[b]       <= '0;
          rpt_armed[b] <= 1'b1;
        end else begin
          rpt[b]       <= rpt[b] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Bench for tt_input_conditioner: behavioural per-bit model checked every cycle plus pinned directed expectations.
// Repeat expectations follow REPEAT_FEATURE_EN when the bundle is built with that macro.
module tb_tt_input_conditioner;

  localparam int W   = 8;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
`ifdef REPEAT_FEATURE_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level_o, rise_o, fall_o;

  int checks = 0;
  int passed = 0;

  tt_input_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_i(raw),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: raw reaches the filter two edges late; a bit flips once it has disagreed with its
  // level on DEB consecutive enabled edges; repeats come DLY then every PER edges after a rise.
  bit [W-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
  int streak [W];
  int since  [W];
  int nrep   [W];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
      for (int b = 0; b < W; b++) begin streak[b] = 0; since[b] = 0; nrep[b] = 0; end
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (!ena) begin
          streak[b] = 0; since[b] = 0; nrep[b] = 0;
        end else begin
          streak[b] = (m_s2[b] != m_level[b]) ? streak[b] + 1 : 0;
          if (streak[b] == DEB) begin
            streak[b]  = 0;
            m_level[b] = m_s2[b];
            since[b]   = 0;
            nrep[b]    = 0;
            if (m_s2[b]) m_rise[b] = 1'b1;
            else         m_fall[b] = 1'b1;
          end else if (REPEAT_ON && m_level[b]) begin
            since[b]++;
            if (since[b] == ((nrep[b] == 0) ? DLY : PER)) begin
              m_rise[b] = 1'b1;
              since[b]  = 0;
              nrep[b]++;
            end
          end else begin
            since[b] = 0; nrep[b] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always @(posedge clk) begin
    #1;
    check("model_level", level_o, m_level);
    check("model_rise", rise_o, m_rise);
    check("model_fall", fall_o, m_fall);
  end

  // Inputs change 3 time units after a rising edge; directed checks sample there too.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  logic [W-1:0] tbl_raw [13] = '{8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'h5A,
                                 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hFF, 8'h00};
  logic         tbl_ena [13] = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1};
  int           tbl_hld [13] = '{8, 3, 6, 2, 10, 5, 7, 3, 2, 9, 12, 40, 12};

  initial begin
    logic [W-1:0] seen_r, seen_f, rep_exp;
    rep_exp = REPEAT_ON ? 8'h02 : 8'h00;

    // Asynchronous reset with all pads high.
    raw = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level_o, 8'h00);
    check("rst_rise", rise_o, 8'h00);
    check("rst_fall", fall_o, 8'h00);
    tick(5);
    check("rst_hold_level", level_o, 8'h00);
    check("rst_hold_rise", rise_o, 8'h00);
    rst_n = 1'b1;
    raw   = 8'h00;
    tick(4);

    // Clean press/release on bit 0: 2 sync edges plus DEB debounce edges.
    raw = 8'h01;
    tick(5);
    check("press_early_level", level_o, 8'h00);
    tick(1);
    check("press_level", level_o, 8'h01);
    check("press_rise", rise_o, 8'h01);
    tick(1);
    check("press_rise_clear", rise_o, 8'h00);
    raw = 8'h00;
    tick(5);
    check("release_early_fall", fall_o, 8'h00);
    tick(1);
    check("release_fall", fall_o, 8'h01);
    check("release_level", level_o, 8'h00);
    tick(1);
    check("release_fall_clear", fall_o, 8'h00);

    // Bounce on bit 3: 2-cycle glitches never qualify, then one rise after settling.
    seen_r = '0; seen_f = '0;
    for (int i = 0; i < 10; i++) begin
      raw[3] = ~raw[3];
      repeat (2) begin tick(1); seen_r |= rise_o; seen_f |= fall_o; end
    end
    check("bounce_no_rise", seen_r, 8'h00);
    check("bounce_no_fall", seen_f, 8'h00);
    raw[3] = 1'b1;
    tick(5);
    check("settle_early_rise", rise_o, 8'h00);
    tick(1);
    check("settle_rise", rise_o, 8'h08);
    raw = 8'h00;
    tick(8);

    // ena low: synchronizer runs, nothing debounces; ena high restarts counting from zero.
    ena = 1'b0;
    raw = 8'h81;
    seen_r = '0;
    repeat (20) begin tick(1); seen_r |= rise_o; end
    check("ena_off_no_rise", seen_r, 8'h00);
    check("ena_off_level", level_o, 8'h00);
    ena = 1'b1;
    tick(3);
    check("ena_on_early_rise", rise_o, 8'h00);
    tick(1);
    check("ena_on_rise", rise_o, 8'h81);
    check("ena_on_level", level_o, 8'h81);
    tick(1);
    check("ena_on_rise_clear", rise_o, 8'h00);
    raw = 8'h00;
    tick(8);

    // Reset mid-debounce: level drops without a fall pulse, full latency needed again.
    raw = 8'h80;
    tick(6);
    check("pre_reset_level", level_o, 8'h80);
    raw = 8'h81;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_level", level_o, 8'h00);
    check("mid_reset_fall", fall_o, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("post_reset_early_level", level_o, 8'h00);
    tick(1);
    check("post_reset_level", level_o, 8'h81);
    check("post_reset_rise", rise_o, 8'h81);
    raw = 8'h00;
    tick(8);

    // Hold bit 1: repeats at T+10, T+13, T+16 (feature on); release after T+13 so the fall
    // lands on T+19 and cancels the repeat due on that same edge.
    raw = 8'h02;
    tick(6);
    check("hold_rise_T", rise_o, 8'h02);
    tick(9);
    check("hold_T9", rise_o, 8'h00);
    tick(1);
    check("hold_T10", rise_o, rep_exp);
    tick(3);
    check("hold_T13", rise_o, rep_exp);
    raw = 8'h00;
    tick(3);
    check("hold_T16", rise_o, rep_exp);
    tick(3);
    check("hold_T19_fall", fall_o, 8'h02);
    check("hold_T19_no_rise", rise_o, 8'h00);
    seen_r = '0; seen_f = '0;
    repeat (20) begin tick(1); seen_r |= rise_o; seen_f |= fall_o; end
    check("after_release_no_rise", seen_r, 8'h00);
    check("after_release_no_fall", seen_f, 8'h00);

    // Multi-bit directed sweep, checked by the model every cycle.
    for (int i = 0; i < 13; i++) begin
      raw = tbl_raw[i];
      ena = tbl_ena[i];
      tick(tbl_hld[i]);
    end
    ena = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
